// File: rtl/data_memory_responder.sv
// data_memory_responder: single-port 32-bit data memory behind a req/ready
// handshake. The memory accepts one transaction at a time, inserts a
// configurable number of wait states and answers with a one-cycle ready pulse.
// Loads and stores both return a word on dmem_read_data. A store returns the
// word it just wrote.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dmem_req,
  input  logic                  dmem_write,
  input  logic [ADDR_WIDTH-1:0] dmem_reg,
  input  logic [31:0]           dmem_write_data,
  output logic [31:0]           dmem_read_data,
  output logic                  dmem_ready,
  output logic                  dmem_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // Wait-state count as loaded into the 4-bit countdown register.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Storage is never reset. Addresses index it directly, so every
  // ADDR_WIDTH-bit value is valid and wraps modulo DEPTH.
  logic [31:0]           mem_q [DEPTH];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic                  accept_s;
  logic                  enter_resp_s;
  logic [ADDR_WIDTH-1:0] txn_addr_s;
  logic                  txn_write_s;
  logic [31:0]           txn_wdata_s;
  logic                  mem_we_s;

  // Next-state logic for the handshake FSM, the wait counter and the capture registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    accept_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dmem_req) begin
          accept_s = 1'b1;
          addr_d   = dmem_reg;
          write_d  = dmem_write;
          wdata_d  = dmem_write_data;
          if (WAIT_LOAD != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // The response lasts exactly one cycle. A request held high is
        // picked up on the next edge, back in IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Choose the transaction that commits on the RESP-entry edge. With zero
  // wait states that edge is also the acceptance edge, so the live inputs
  // are used. Otherwise the captured copies are used.
  always_comb begin
    if (accept_s) begin
      txn_addr_s  = dmem_reg;
      txn_write_s = dmem_write;
      txn_wdata_s = dmem_write_data;
    end else begin
      txn_addr_s  = addr_q;
      txn_write_s = write_q;
      txn_wdata_s = wdata_q;
    end
  end

  // Compute the response data and the registered ready/busy values from the next state.
  always_comb begin
    enter_resp_s = (state_d == S_RESP) && (state_q != S_RESP);
    mem_we_s     = enter_resp_s && txn_write_s;
    ready_d      = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
    if (enter_resp_s) begin
      if (txn_write_s) begin
        rdata_d = txn_wdata_s;
      end else begin
        rdata_d = mem_q[txn_addr_s];
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // FSM, counter, capture and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Store commit on the RESP-entry edge. The reset branch intentionally
  // leaves the contents untouched. It also blocks commits on any clock
  // edge that arrives while reset_n is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
    end else if (mem_we_s) begin
      mem_q[txn_addr_s] <= txn_wdata_s;
    end
  end

  assign dmem_read_data = rdata_q;
  assign dmem_ready     = ready_q;
  assign dmem_busy      = busy_q;

endmodule
